ram_pair_alu_engine: RTL and testbench
======================================

RAM_PAIR_ALU_ENGINE -- requirements
Module: ram_pair_alu_engine

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter DATA_W, default 8, sets the RAM word width.
REQ-003 Parameter ADDR_W, default 9, sets the RAM address width; depth is 2^ADDR_W.
REQ-004 CLOCK_50_I  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 RESET_I  input  1  asynchronous, active-high reset.
REQ-006 start_i  input  1  single-cycle request; sampled only in S_IDLE.
REQ-007 abort_i  input  1  terminates a run in progress.
REQ-008 base_addr_i  input  ADDR_W  first address of the run.
REQ-009 length_i  input  ADDR_W+1  number of words to process.
REQ-010 op0_i, op1_i  input  3 each  operation for channel 0 and channel 1.
REQ-011 ch_en_i  input  2  per-channel write enable mask.
REQ-012 ram_rd_addr_o  output  ADDR_W  shared read address for port a of RAM0 and RAM1.
REQ-013 ram0_rd_data_i, ram1_rd_data_i  input  DATA_W each  port a read data; synchronous RAM, valid one cycle after the address.
REQ-014 ram_wr_addr_o  output  ADDR_W  shared write address for port b.
REQ-015 ram0_wr_data_o, ram1_wr_data_o  output  DATA_W each  port b write data.
REQ-016 ram0_wr_en_o, ram1_wr_en_o  output  1 each  port b write enables.
REQ-017 busy_o, done_o  output  1 each  run active; one-cycle completion pulse.
REQ-018 checksum_o  output  DATA_W  running XOR of every word written this run.

Function
REQ-019 FSM states SHALL be S_IDLE, S_READ_WRITE, S_LAST_WRITE and S_DONE.
REQ-020 In S_IDLE with start_i=1, the block SHALL latch base, length (clamped to 2^ADDR_W), op0/op1 and ch_en, and clear checksum_o.
REQ-021 From S_IDLE with start_i=1 and a nonzero clamped length, the FSM SHALL enter S_READ_WRITE with ram_rd_addr_o=base.
REQ-022 With length 0, the FSM SHALL go directly to S_DONE and perform no writes.
REQ-023 Each S_READ_WRITE cycle SHALL issue one read and increment ram_rd_addr_o modulo 2^ADDR_W.
REQ-024 After L reads have been issued, the FSM SHALL enter S_LAST_WRITE.
REQ-025 The write of element k SHALL occur exactly one cycle after its read: ram_wr_addr_o=(base+k) mod 2^ADDR_W.
REQ-026 On that write, ramN_wr_en_o SHALL equal the latched ch_en[N]; write addresses and enables are registered.
REQ-027 ramN_wr_data_o SHALL be combinational from ram0_rd_data_i (A) and ram1_rd_data_i (B) per the latched opN.
REQ-028 Opcode map: 0 A+B wrapping; 1 A-B wrapping; 2 A+B unsigned saturating to 2^DATA_W-1; 3 A-B saturating to 0; 4 |A-B|; 5 max(A,B); 6 min(A,B); 7 A.
REQ-029 Timing for start at cycle t with length L>0: busy_o=1 in cycles t+1..t+1+L; writes in cycles t+2..t+1+L; done_o=1 only in cycle t+2+L (S_DONE); S_IDLE follows.
REQ-030 For length 0: done_o=1 in cycle t+1 and busy_o stays 0.
REQ-031 Write enables SHALL never be asserted outside the write cycles defined above; S_DONE and S_IDLE drive both enables to 0.
REQ-032 checksum_o SHALL XOR in each enabled channel's write data on every write cycle and hold its value until the next accepted start.
REQ-033 start_i SHALL be ignored outside S_IDLE.
REQ-034 abort_i=1 in S_READ_WRITE or S_LAST_WRITE SHALL force both write enables to 0 from the next cycle and return the FSM to S_IDLE without pulsing done_o.
REQ-035 abort_i SHALL take priority over a write that would otherwise occur in the following cycle.
REQ-036 Address wrap past 2^ADDR_W-1 to 0 SHALL be seamless for both read and write addresses.
REQ-037 The read address SHALL never equal the write address in the same cycle.

Reset
REQ-038 While RESET_I=1 the block SHALL be in S_IDLE, with all address outputs at 0, both write enables 0, busy_o=0, done_o=0, checksum_o=0 and all latched configuration cleared.
REQ-039 Reset asserted mid-run SHALL take effect immediately (asynchronously) with the same values; no partial write may occur after the reset edge.

Verification
REQ-040 RAM0[k]=k, RAM1[k]=1, base 0, L=4, ops 0/1, ch_en=11 -> RAM0[0..3]=1,2,3,4; RAM1[0..3]=255,0,1,2; done_o at t+6; checksum_o equals the XOR of those eight words.
REQ-041 A=200, B=100, ops 2/3, L=1 -> RAM0=255, RAM1=100; with A=100, B=200 -> RAM0=255 (300 saturated), RAM1=0.
REQ-042 base 510, L=4, ADDR_W=9 -> writes land at addresses 510, 511, 0, 1 in order.
REQ-043 L=0 -> done_o at t+1, no write enable ever asserted; L=600 -> clamped to 512 words.
REQ-044 abort_i in the 3rd S_READ_WRITE cycle of an L=10 run -> exactly 2 writes occur, no done_o, FSM back in S_IDLE; start_i during busy_o has no effect.
REQ-045 RESET_I asserted at cycle t+3 of an L=8 run -> all outputs at reset values within the same cycle, and no write occurs at the next edge.

Source files
------------

// File: rtl/ram_pair_alu_engine.sv
// Streams a block of words from two synchronous RAMs through per-channel ALU ops and writes the results back in place.
// Read-to-write latency is one cycle. There is no backpressure: once started, a run proceeds at one word per cycle until it finishes or is aborted.
module ram_pair_alu_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              CLOCK_50_I,
  input  logic              RESET_I,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   length_i,
  input  logic [2:0]        op0_i,
  input  logic [2:0]        op1_i,
  input  logic [1:0]        ch_en_i,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [DATA_W-1:0] ram0_rd_data_i,
  input  logic [DATA_W-1:0] ram1_rd_data_i,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [DATA_W-1:0] ram0_wr_data_o,
  output logic [DATA_W-1:0] ram1_wr_data_o,
  output logic              ram0_wr_en_o,
  output logic              ram1_wr_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] checksum_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ_WRITE,
    S_LAST_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t          state;
  logic [ADDR_W:0] reads_left;
  logic [2:0]      op0_q;
  logic [2:0]      op1_q;
  logic [1:0]      ch_en_q;
  logic [ADDR_W:0] len_clamped;

  function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      3'd0:    alu = a + b;
      3'd1:    alu = a - b;
      3'd2:    alu = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
      3'd3:    alu = (a > b) ? a - b : '0;
      3'd4:    alu = (a >= b) ? a - b : b - a;
      3'd5:    alu = (a > b) ? a : b;
      3'd6:    alu = (a < b) ? a : b;
      default: alu = a;
    endcase
  endfunction

  assign len_clamped    = (length_i > DEPTH) ? DEPTH : length_i;
  assign ram0_wr_data_o = alu(op0_q, ram0_rd_data_i, ram1_rd_data_i);
  assign ram1_wr_data_o = alu(op1_q, ram0_rd_data_i, ram1_rd_data_i);

  always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
    if (RESET_I) begin
      state         <= S_IDLE;
      reads_left    <= '0;
      op0_q         <= '0;
      op1_q         <= '0;
      ch_en_q       <= '0;
      ram_rd_addr_o <= '0;
      ram_wr_addr_o <= '0;
      ram0_wr_en_o  <= 1'b0;
      ram1_wr_en_o  <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      checksum_o    <= '0;
    end else begin
      done_o       <= 1'b0;
      ram0_wr_en_o <= 1'b0;
      ram1_wr_en_o <= 1'b0;
      // Fold in whatever is being written this cycle; enables are never set in S_IDLE.
      checksum_o <= checksum_o
                    ^ ({DATA_W{ram0_wr_en_o}} & ram0_wr_data_o)
                    ^ ({DATA_W{ram1_wr_en_o}} & ram1_wr_data_o);
      case (state)
        S_IDLE: begin
          if (start_i) begin
            op0_q         <= op0_i;
            op1_q         <= op1_i;
            ch_en_q       <= ch_en_i;
            reads_left    <= len_clamped;
            checksum_o    <= '0;
            ram_rd_addr_o <= base_addr_i;
            // Parked one behind the read pointer so the two never collide.
            ram_wr_addr_o <= base_addr_i - 1'b1;
            if (len_clamped == '0) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              state  <= S_READ_WRITE;
              busy_o <= 1'b1;
            end
          end
        end
        S_READ_WRITE: begin
          if (abort_i) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end else begin
            ram0_wr_en_o  <= ch_en_q[0];
            ram1_wr_en_o  <= ch_en_q[1];
            ram_wr_addr_o <= ram_rd_addr_o;
            ram_rd_addr_o <= ram_rd_addr_o + 1'b1;
            reads_left    <= reads_left - 1'b1;
            if (reads_left == {{ADDR_W{1'b0}}, 1'b1})
              state <= S_LAST_WRITE;
          end
        end
        S_LAST_WRITE: begin
          busy_o <= 1'b0;
          if (abort_i) begin
            state <= S_IDLE;
          end else begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_pair_alu_engine.sv
// Directed bench for ram_pair_alu_engine with a behavioural dual-RAM model.
module tb_ram_pair_alu_engine;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [8:0] base_addr_i = '0;
  logic [9:0] length_i = '0;
  logic [2:0] op0_i = '0;
  logic [2:0] op1_i = '0;
  logic [1:0] ch_en_i = '0;
  logic [8:0] ram_rd_addr_o;
  logic [7:0] ram0_rd_data_i = '0;
  logic [7:0] ram1_rd_data_i = '0;
  logic [8:0] ram_wr_addr_o;
  logic [7:0] ram0_wr_data_o;
  logic [7:0] ram1_wr_data_o;
  logic       ram0_wr_en_o;
  logic       ram1_wr_en_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] checksum_o;

  logic       pl_en = 1'b0;
  logic [8:0] pl_addr = '0;
  logic [7:0] pl_d0 = '0;
  logic [7:0] pl_d1 = '0;

  logic [7:0] mem0 [512];
  logic [7:0] mem1 [512];
  logic [8:0] wlog [2048];
  int         wr0_cnt = 0;
  int         wr1_cnt = 0;
  int         done_cnt = 0;

  int vectors = 0;
  int miscompares = 0;

  ram_pair_alu_engine #(.DATA_W(8), .ADDR_W(9)) dut (
    .CLOCK_50_I     (clk_50),
    .RESET_I        (reset),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .base_addr_i    (base_addr_i),
    .length_i       (length_i),
    .op0_i          (op0_i),
    .op1_i          (op1_i),
    .ch_en_i        (ch_en_i),
    .ram_rd_addr_o  (ram_rd_addr_o),
    .ram0_rd_data_i (ram0_rd_data_i),
    .ram1_rd_data_i (ram1_rd_data_i),
    .ram_wr_addr_o  (ram_wr_addr_o),
    .ram0_wr_data_o (ram0_wr_data_o),
    .ram1_wr_data_o (ram1_wr_data_o),
    .ram0_wr_en_o   (ram0_wr_en_o),
    .ram1_wr_en_o   (ram1_wr_en_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .checksum_o     (checksum_o)
  );

  always #10 clk_50 = ~clk_50;

  // RAM pair: synchronous read on port a, write on port b, plus a preload path.
  always @(posedge clk_50) begin
    if (pl_en) begin
      mem0[pl_addr] <= pl_d0;
      mem1[pl_addr] <= pl_d1;
    end else begin
      if (ram0_wr_en_o) begin
        mem0[ram_wr_addr_o] <= ram0_wr_data_o;
        wlog[wr0_cnt % 2048] <= ram_wr_addr_o;
        wr0_cnt = wr0_cnt + 1;
      end
      if (ram1_wr_en_o) begin
        mem1[ram_wr_addr_o] <= ram1_wr_data_o;
        wr1_cnt = wr1_cnt + 1;
      end
    end
    if (done_o) done_cnt = done_cnt + 1;
    ram0_rd_data_i <= mem0[ram_rd_addr_o];
    ram1_rd_data_i <= mem1[ram_rd_addr_o];
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic preload(input int addr, input int d0, input int d1);
    pl_en   = 1'b1;
    pl_addr = 9'(addr);
    pl_d0   = 8'(d0);
    pl_d1   = 8'(d1);
    tick();
    pl_en = 1'b0;
  endtask

  // Drives start in cycle t and returns in cycle t+1.
  task automatic launch(input int base, input int len, input int o0, input int o1, input int ch);
    base_addr_i = 9'(base);
    length_i    = 10'(len);
    op0_i       = 3'(o0);
    op1_i       = 3'(o1);
    ch_en_i     = 2'(ch);
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // n is the cycle offset from t at which done_o is seen (budget on expiry).
  task automatic wait_done(input int n0, input int budget, output int n);
    n = n0;
    while (!done_o && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int w0;
    int w1;
    int dc;

    // Reset state
    tick();
    tick();
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_wen", {ram0_wr_en_o, ram1_wr_en_o}, 0);
    check("rst_rd_addr", ram_rd_addr_o, 0);
    check("rst_wr_addr", ram_wr_addr_o, 0);
    check("rst_checksum", checksum_o, 0);
    reset = 1'b0;
    tick();

    // Basic add/sub run, with a stray start while busy
    for (int k = 0; k < 5; k++) preload(k, k, 1);
    w0 = wr0_cnt;
    w1 = wr1_cnt;
    dc = done_cnt;
    launch(0, 4, 0, 1, 3);
    check("t1_busy", busy_o, 1);
    check("t1_rd_addr", ram_rd_addr_o, 0);
    check("t1_no_wen", {ram0_wr_en_o, ram1_wr_en_o}, 0);
    tick();
    check("t2_wen", {ram0_wr_en_o, ram1_wr_en_o}, 3);
    check("t2_wr_addr", ram_wr_addr_o, 0);
    check("t2_wr_data0", ram0_wr_data_o, 1);
    check("t2_wr_data1", ram1_wr_data_o, 255);
    base_addr_i = 9'd300;
    length_i    = 10'd0;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(3, 40, n);
    check("basic_done_cycle", n, 6);
    check("basic_busy_at_done", busy_o, 0);
    check("basic_wen_at_done", {ram0_wr_en_o, ram1_wr_en_o}, 0);
    check("basic_checksum", checksum_o, 248);
    tick();
    check("basic_done_pulse", done_o, 0);
    check("basic_ram0_0", mem0[0], 1);
    check("basic_ram0_3", mem0[3], 4);
    check("basic_ram1_0", mem1[0], 255);
    check("basic_ram1_1", mem1[1], 0);
    check("basic_ram1_3", mem1[3], 2);
    check("basic_ram0_4_untouched", mem0[4], 4);
    check("basic_wr_count", (wr0_cnt - w0) + (wr1_cnt - w1), 8);
    check("basic_done_count", done_cnt - dc, 1);
    check("basic_checksum_hold", checksum_o, 248);

    // Saturating ops
    preload(0, 200, 100);
    launch(0, 1, 2, 3, 3);
    wait_done(1, 40, n);
    check("sat1_done_cycle", n, 3);
    tick();
    check("sat1_ram0", mem0[0], 255);
    check("sat1_ram1", mem1[0], 100);
    check("sat1_checksum", checksum_o, 155);
    preload(0, 100, 200);
    launch(0, 1, 2, 3, 3);
    wait_done(1, 40, n);
    tick();
    check("sat2_ram0", mem0[0], 255);
    check("sat2_ram1", mem1[0], 0);

    // abs-diff / max, then min / pass-A
    preload(10, 30, 50);
    preload(11, 80, 20);
    launch(10, 2, 4, 5, 3);
    wait_done(1, 40, n);
    tick();
    check("absd_10", mem0[10], 20);
    check("absd_11", mem0[11], 60);
    check("max_10", mem1[10], 50);
    check("max_11", mem1[11], 80);
    preload(10, 30, 50);
    preload(11, 80, 20);
    launch(10, 2, 6, 7, 3);
    wait_done(1, 40, n);
    check("minA_checksum", checksum_o, 68);
    tick();
    check("min_10", mem0[10], 30);
    check("min_11", mem0[11], 20);
    check("passA_11", mem1[11], 80);

    // Address wrap, channel 0 only
    preload(510, 5, 9);
    preload(511, 6, 9);
    preload(0, 7, 9);
    preload(1, 8, 9);
    w0 = wr0_cnt;
    w1 = wr1_cnt;
    launch(510, 4, 7, 0, 1);
    wait_done(1, 40, n);
    check("wrap_done_cycle", n, 6);
    tick();
    check("wrap_addr0", wlog[w0 % 2048], 510);
    check("wrap_addr1", wlog[(w0 + 1) % 2048], 511);
    check("wrap_addr2", wlog[(w0 + 2) % 2048], 0);
    check("wrap_addr3", wlog[(w0 + 3) % 2048], 1);
    check("wrap_ram0_0", mem0[0], 7);
    check("wrap_ch1_writes", wr1_cnt - w1, 0);

    // Zero length
    w0 = wr0_cnt;
    w1 = wr1_cnt;
    launch(5, 0, 0, 0, 3);
    check("len0_done", done_o, 1);
    check("len0_busy", busy_o, 0);
    tick();
    check("len0_done_pulse", done_o, 0);
    tick();
    check("len0_writes", (wr0_cnt - w0) + (wr1_cnt - w1), 0);

    // Length clamp
    w0 = wr0_cnt;
    launch(0, 600, 7, 7, 1);
    wait_done(1, 700, n);
    check("clamp_done_cycle", n, 514);
    tick();
    check("clamp_writes", wr0_cnt - w0, 512);

    // Abort in the third read/write cycle
    w0 = wr0_cnt;
    w1 = wr1_cnt;
    dc = done_cnt;
    launch(40, 10, 7, 7, 3);
    tick();
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_wen", {ram0_wr_en_o, ram1_wr_en_o}, 0);
    check("abort_busy", busy_o, 0);
    for (int i = 0; i < 6; i++) tick();
    check("abort_wr0", wr0_cnt - w0, 2);
    check("abort_wr1", wr1_cnt - w1, 2);
    check("abort_no_done", done_cnt - dc, 0);

    // Reset in the middle of a run
    for (int k = 0; k < 4; k++) preload(20 + k, 10 + k, 1);
    w0 = wr0_cnt;
    dc = done_cnt;
    launch(20, 8, 0, 0, 3);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_wen", {ram0_wr_en_o, ram1_wr_en_o}, 0);
    check("mid_rst_rd_addr", ram_rd_addr_o, 0);
    check("mid_rst_wr_addr", ram_wr_addr_o, 0);
    check("mid_rst_checksum", checksum_o, 0);
    tick();
    reset = 1'b0;
    tick();
    check("mid_rst_writes", wr0_cnt - w0, 1);
    check("mid_rst_ram0_20", mem0[20], 11);
    check("mid_rst_ram0_21", mem0[21], 11);
    check("mid_rst_no_done", done_cnt - dc, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
